// File: rtl/ones_count_datapath_pkg.sv
// ones_count_pkg: shared defaults and the counter-width helper for ones_count_datapath.
package ones_count_pkg;

    localparam int WIDTH_DEF = 8;

    // Counter must hold the value WIDTH itself, hence width+1 codes.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ones_count_datapath_if.sv
// Controller <-> datapath bundle: T-state lines, start, operand and the status/result returned.
interface ones_count_datapath_if
    import ones_count_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = cnt_w(WIDTH)
);

    logic             S;
    logic             T0;
    logic             T1;
    logic             T2;
    logic [WIDTH-1:0] DIN;
    logic             Z;
    logic             X;
    logic [CNT_W-1:0] COUNT;
    logic             DONE;
    logic             ERR;

    modport master (
        output S, T0, T1, T2, DIN,
        input  Z, X, COUNT, DONE, ERR
    );

    modport slave (
        input  S, T0, T1, T2, DIN,
        output Z, X, COUNT, DONE, ERR
    );

endinterface

// File: rtl/ones_count_datapath_bit_scan_reg.sv
// bit_scan_reg: scan shift register A plus remaining-bit counter CNT; exports Z, lsb and X = lsb | Z.
module bit_scan_reg
    import ones_count_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             hold,
    input  logic [WIDTH-1:0] din,
    output logic             z,
    output logic             lsb,
    output logic             x
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign z   = (cnt_q == '0);
    assign lsb = a_q[0];
    assign x   = lsb | z;

    // Shifting is also gated by !z here so CNT can never wrap below zero.
    always_comb begin
        a_d   = a_q;
        cnt_d = cnt_q;
        if (!hold) begin
            if (load) begin
                a_d   = din;
                cnt_d = CNT_W'(WIDTH);
            end else if (shift && !z) begin
                a_d   = a_q >> 1;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ones_count_datapath.sv
// ones_count_datapath: ASM datapath counting 1 bits of DIN under T0/T1/T2 control.
// Optional macro ONES_COUNT_DATAPATH_ONEHOT_CHECK_EN adds a sticky one-hot check on ERR.
module ones_count_datapath
    import ones_count_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input logic                  CLK,
    input logic                  RST_N,
    ones_count_datapath_if.slave bus
);

    logic             sel_t0;
    logic             sel_t1;
    logic             sel_t2;
    logic             load;
    logic             shift;
    logic             hold;
    logic             tally;
    logic             finish;
    logic             z;
    logic             lsb;
    logic             x;
    logic             done_block;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] ones_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             done_q;
    logic             done_d;

    // Priority decode keeps actions well defined even if the T lines are not one-hot.
    assign sel_t0 = bus.T0;
    assign sel_t1 = !bus.T0 && bus.T1;
    assign sel_t2 = !bus.T0 && !bus.T1 && bus.T2;

    assign load   = sel_t0 && bus.S;
    assign tally  = sel_t2 && !z;
    assign finish = sel_t2 && z;
    assign shift  = (sel_t1 && !x) || tally;
    assign hold   = !(bus.T0 || bus.T1 || bus.T2);

`ifdef ONES_COUNT_DATAPATH_ONEHOT_CHECK_EN
    logic err_q;
    logic err_d;
    logic one_hot;

    always_comb begin
        one_hot = 1'b0;
        case ({bus.T0, bus.T1, bus.T2})
            3'b100, 3'b010, 3'b001: one_hot = 1'b1;
            default:                one_hot = 1'b0;
        endcase
    end

    assign err_d      = err_q || !one_hot;
    assign done_block = err_q || !one_hot;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.ERR = err_q;
`else
    assign done_block = 1'b0;
    assign bus.ERR    = 1'b0;
`endif

    always_comb begin
        ones_d  = ones_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            ones_d = '0;
        end else if (tally) begin
            ones_d = ones_q + CNT_W'(lsb);
        end
        if (finish) begin
            count_d = ones_q;
            done_d  = !done_block;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ones_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            ones_q  <= ones_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    bit_scan_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_scan (
        .clk   (CLK),
        .rst_n (RST_N),
        .load  (load),
        .shift (shift),
        .hold  (hold),
        .din   (bus.DIN),
        .z     (z),
        .lsb   (lsb),
        .x     (x)
    );

    assign bus.Z     = z;
    assign bus.X     = x;
    assign bus.COUNT = count_q;
    assign bus.DONE  = done_q;

endmodule

// File: tb/tb_ones_count_datapath.sv
// tb_ones_count_datapath: WIDTH=8 and WIDTH=4 datapaths, each closed through a behavioural
// three-state controller; results checked against popcount and the WIDTH+2+R latency rule.
module tb_ones_count_datapath;
    import ones_count_pkg::*;

    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    ones_count_datapath_if #(.WIDTH(8)) bus8 ();
    ones_count_datapath_if #(.WIDTH(4)) bus4 ();

    ones_count_datapath #(.WIDTH(8)) dut8 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus8.slave)
    );

    ones_count_datapath #(.WIDTH(4)) dut4 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus4.slave)
    );

    // Controller state: 0 = T0, 1 = T1, 2 = T2. ovr lets the bench drive the T lines directly.
    int         ctl8 = 0;
    int         ctl4 = 0;
    logic       ovr = 1'b0;
    logic [2:0] ovr_t = 3'b000;

    assign bus8.T0 = ovr ? ovr_t[2] : (ctl8 == 0);
    assign bus8.T1 = ovr ? ovr_t[1] : (ctl8 == 1);
    assign bus8.T2 = ovr ? ovr_t[0] : (ctl8 == 2);
    assign bus4.T0 = (ctl4 == 0);
    assign bus4.T1 = (ctl4 == 1);
    assign bus4.T2 = (ctl4 == 2);

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctl8 <= 0;
        end else if (!ovr) begin
            case (ctl8)
                0:       if (bus8.S) ctl8 <= 1;
                1:       if (bus8.X) ctl8 <= 2;
                2:       if (bus8.Z) ctl8 <= 0; else if (!bus8.X) ctl8 <= 1;
                default: ctl8 <= 0;
            endcase
        end
    end

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctl4 <= 0;
        end else begin
            case (ctl4)
                0:       if (bus4.S) ctl4 <= 1;
                1:       if (bus4.X) ctl4 <= 2;
                2:       if (bus4.Z) ctl4 <= 0; else if (!bus4.X) ctl4 <= 1;
                default: ctl4 <= 0;
            endcase
        end
    end

    int tests = 0;
    int fails = 0;
    int last_count = 0;

    typedef struct {
        logic [7:0] din;
        int         exp_count;
        int         exp_lat;
    } vec_t;

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int refOnes(input logic [7:0] w, input int width);
        int n = 0;
        for (int i = 0; i < width; i++) n += int'(w[i]);
        return n;
    endfunction

    // Each 1 followed by a 0 (LSB-first) costs one extra hand-off cycle.
    function automatic int refLatency(input logic [7:0] w, input int width);
        int r = 0;
        for (int i = 0; i < width - 1; i++) if (w[i] && !w[i+1]) r++;
        return width + 2 + r;
    endfunction

    // Start one 8-bit word and wait (bounded) for DONE; lat is edges after the start edge.
    task automatic applyStimulus(input logic [7:0] din, input int freeze_at, input int freeze_len,
                                 input int budget, output int lat, output bit seen);
        bus8.S   = 1'b1;
        bus8.DIN = din;
        @(negedge CLK);
        checkOutput("count_hold_on_start", int'(bus8.COUNT), last_count);
        checkOutput("done_low_after_start", int'(bus8.DONE), 0);
        bus8.S   = 1'($urandom_range(0, 1));
        bus8.DIN = 8'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < budget) begin
            if (lat == freeze_at) begin
                ovr   = 1'b1;
                ovr_t = 3'b000;
            end
            if (lat == freeze_at + freeze_len) ovr = 1'b0;
            @(negedge CLK);
            lat++;
            seen     = bus8.DONE;
            bus8.S   = seen ? 1'b0 : 1'($urandom_range(0, 1));
            bus8.DIN = 8'($urandom);
        end
        ovr    = 1'b0;
        bus8.S = 1'b0;
    endtask

    initial begin
        vec_t       vecs[6];
        int         lat;
        bit         seen;
        bit         any_done;
        logic [7:0] w;
        int         exp_tr[8];

        vecs[0] = '{8'h00, 0, 10};
        vecs[1] = '{8'hFF, 8, 10};
        vecs[2] = '{8'hA5, 4, 13};
        vecs[3] = '{8'h01, 1, 11};
        vecs[4] = '{8'h80, 1, 10};
        vecs[5] = '{8'h55, 4, 14};
        exp_tr  = '{1, 2, 2, 1, 2, 2, 1, 2};

        bus8.S   = 1'b0;
        bus8.DIN = '0;
        bus4.S   = 1'b0;
        bus4.DIN = '0;
        RST_N    = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        checkOutput("reset_z", int'(bus8.Z), 1);
        checkOutput("reset_x", int'(bus8.X), 1);
        checkOutput("reset_count", int'(bus8.COUNT), 0);
        checkOutput("reset_done", int'(bus8.DONE), 0);
        checkOutput("reset_err", int'(bus8.ERR), 0);
        checkOutput("reset_w4_z", int'(bus4.Z), 1);
        checkOutput("reset_w4_count", int'(bus4.COUNT), 0);

        // Back-to-back table runs: each start lands on the edge right after the previous DONE.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].din, -1, 0, 60, lat, seen);
            checkOutput($sformatf("tbl%0d_done_seen", i), int'(seen), 1);
            checkOutput($sformatf("tbl%0d_latency", i), lat, vecs[i].exp_lat);
            checkOutput($sformatf("tbl%0d_count", i), int'(bus8.COUNT), vecs[i].exp_count);
            last_count = vecs[i].exp_count;
        end

        for (int k = 0; k < 25; k++) begin
            w = 8'($urandom);
            applyStimulus(w, -1, 0, 60, lat, seen);
            checkOutput("rnd_done_seen", int'(seen), 1);
            checkOutput("rnd_latency", lat, refLatency(w, 8));
            checkOutput("rnd_count", int'(bus8.COUNT), refOnes(w, 8));
            last_count = refOnes(w, 8);
        end

        // WIDTH=4, DIN=0101: controller trace T1,T2,T2,T1,T2,T2,T1,T2 then DONE with COUNT=2.
        @(negedge CLK);
        bus4.S   = 1'b1;
        bus4.DIN = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            bus4.S   = 1'b0;
            bus4.DIN = 4'($urandom);
            checkOutput($sformatf("w4_trace%0d", k), ctl4, exp_tr[k]);
            checkOutput("w4_done_early", int'(bus4.DONE), 0);
        end
        @(negedge CLK);
        checkOutput("w4_done", int'(bus4.DONE), 1);
        checkOutput("w4_count", int'(bus4.COUNT), 2);
        @(negedge CLK);
        checkOutput("w4_done_pulse", int'(bus4.DONE), 0);
        checkOutput("w4_count_stable", int'(bus4.COUNT), 2);

        // No T line active for 4 edges mid-scan.
        applyStimulus(8'hA5, 3, 4, 20, lat, seen);
`ifdef ONES_COUNT_DATAPATH_ONEHOT_CHECK_EN
        checkOutput("freeze_err_set", int'(bus8.ERR), 1);
        checkOutput("freeze_done_blocked", int'(seen), 0);
`else
        checkOutput("freeze_done_seen", int'(seen), 1);
        checkOutput("freeze_latency", lat, 17);
        checkOutput("freeze_count", int'(bus8.COUNT), 4);
        checkOutput("freeze_err_zero", int'(bus8.ERR), 0);
`endif

        // Reset mid-scan: outputs clear before any clock edge, and no DONE follows.
        bus8.S   = 1'b1;
        bus8.DIN = 8'hA5;
        @(negedge CLK);
        bus8.S = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        checkOutput("async_rst_z", int'(bus8.Z), 1);
        checkOutput("async_rst_x", int'(bus8.X), 1);
        checkOutput("async_rst_count", int'(bus8.COUNT), 0);
        checkOutput("async_rst_done", int'(bus8.DONE), 0);
        checkOutput("async_rst_err", int'(bus8.ERR), 0);
        @(negedge CLK);
        RST_N      = 1'b1;
        last_count = 0;
        any_done   = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (bus8.DONE) any_done = 1'b1;
        end
        checkOutput("no_done_after_reset", int'(any_done), 0);
        checkOutput("idle_count_after_reset", int'(bus8.COUNT), 0);

`ifdef ONES_COUNT_DATAPATH_ONEHOT_CHECK_EN
        ovr   = 1'b1;
        ovr_t = 3'b011;
        @(negedge CLK);
        ovr = 1'b0;
        checkOutput("multi_hot_err", int'(bus8.ERR), 1);
        applyStimulus(8'hFF, -1, 0, 30, lat, seen);
        checkOutput("err_blocks_done", int'(seen), 0);
        checkOutput("err_sticky", int'(bus8.ERR), 1);
`else
        applyStimulus(8'h3C, -1, 0, 60, lat, seen);
        checkOutput("post_reset_done_seen", int'(seen), 1);
        checkOutput("post_reset_latency", lat, refLatency(8'h3C, 8));
        checkOutput("post_reset_count", int'(bus8.COUNT), 4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
